// File: rtl/mag_cmp_pkg.sv
// Shared definitions for the sequential magnitude comparator.
//   state_e  : controller states (IDLE, SCAN, DONE)
//   ndig     : number of DIGIT-bit slices in a WIDTH-bit operand
//   idx_bits : width of the slice index register (minimum 1 bit)
package mag_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // A single-slice compare still needs a 1-bit index register.
  function automatic int idx_bits(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/digit_compare.sv
// Purely combinational compare of one DIGIT-bit unsigned slice.
//   a_i, b_i : slices to compare
//   eq_o     : a_i == b_i
//   gt_o     : a_i >  b_i   (less-than is derived by the user as ~eq & ~gt)
module digit_compare #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  output logic             eq_o,
  output logic             gt_o
);

  assign eq_o = (a_i == b_i);
  assign gt_o = (a_i >  b_i);

endmodule

// File: rtl/mag_compare_seq.sv
// Sequential magnitude comparator: compares two WIDTH-bit operands one
// DIGIT-bit slice per clock, most significant slice first, and stops at the
// first slice that differs. Signed mode flips the operand sign bits so the
// scan itself is always an unsigned compare.
//   clk, reset      : rising-edge clock, asynchronous active-high reset
//   start           : request a compare (accepted only in IDLE)
//   signed_mode, a, b : operands and mode, latched with start
//   busy            : high while slices are being scanned
//   done            : one-cycle pulse when the result becomes valid
//   equalto, greaterthan, lessthan : one-hot result, held until next start
module mag_compare_seq
  import mag_cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             equalto,
  output logic             greaterthan,
  output logic             lessthan
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int IW   = idx_bits(NDIG);

  localparam logic [IW-1:0] IDX_TOP = IW'(NDIG - 1);
  localparam logic [IW-1:0] IDX_ONE = IW'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             eq_q, eq_d;
  logic             gt_q, gt_d;
  logic             lt_q, lt_d;

  // Slice view of the latched operands, indexed by the scan position.
  logic [DIGIT-1:0] dig_a [NDIG];
  logic [DIGIT-1:0] dig_b [NDIG];

  for (genvar g = 0; g < NDIG; g++) begin : g_slice
    assign dig_a[g] = ra_q[g*DIGIT +: DIGIT];
    assign dig_b[g] = rb_q[g*DIGIT +: DIGIT];
  end

  logic dig_eq, dig_gt, dig_lt;

  digit_compare #(
    .DIGIT(DIGIT)
  ) u_digit_compare (
    .a_i (dig_a[idx_q]),
    .b_i (dig_b[idx_q]),
    .eq_o(dig_eq),
    .gt_o(dig_gt)
  );

  assign dig_lt = ~dig_eq & ~dig_gt;

  always_comb begin
    // NOTE: every next-state value defaults to its current value first so no
    // path through the case statement can leave one unassigned (no latches).
    state_d = state_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    idx_d   = idx_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    lt_d    = lt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Inverting the sign bit maps two's complement onto offset binary,
          // which orders identically under an unsigned compare.
          ra_d            = a;
          ra_d[WIDTH-1]   = a[WIDTH-1] ^ signed_mode;
          rb_d            = b;
          rb_d[WIDTH-1]   = b[WIDTH-1] ^ signed_mode;
          idx_d           = IDX_TOP;
          eq_d            = 1'b0;
          gt_d            = 1'b0;
          lt_d            = 1'b0;
          state_d         = SCAN;
        end
      end

      SCAN: begin
        if (dig_gt) begin
          gt_d    = 1'b1;
          state_d = DONE;
        end else if (dig_lt) begin
          lt_d    = 1'b1;
          state_d = DONE;
        end else if (idx_q == '0) begin
          eq_d    = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q - IDX_ONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: the operand registers are ordinary flops (not a memory), so they are
  // cleared by reset along with the rest of the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      idx_q   <= '0;
      eq_q    <= 1'b0;
      gt_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      idx_q   <= idx_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      lt_q    <= lt_d;
    end
  end

  assign busy        = (state_q == SCAN);
  assign done        = (state_q == DONE);
  assign equalto     = eq_q;
  assign greaterthan = gt_q;
  assign lessthan    = lt_q;

endmodule

// File: tb/tb_mag_compare_seq.sv
// Scoreboard bench for mag_compare_seq. Two instances: 32-bit/4-bit slices and
// 8-bit/1-bit slices. Stimulus pushes the hand-computed result and latency;
// per-instance monitors pop and compare whenever done is seen.
// Latency k counts the start edge as cycle 1, so done observed after edge D
// for a start sampled at edge E gives k = D - E + 1.
module tb_mag_compare_seq;

  typedef struct {
    logic eq;
    logic gt;
    logic lt;
    int   edge_cyc;
    int   k;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start0, sm0, start1, sm1;
  logic [31:0] a0, b0;
  logic [7:0]  a1, b1;
  logic        busy0, done0, eq0, gt0, lt0;
  logic        busy1, done1, eq1, gt1, lt1;

  int cyc = 0;
  int total = 0;
  int bad = 0;
  int bc0 = 0;
  int bc1 = 0;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mag_compare_seq #(.WIDTH(32), .DIGIT(4)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .signed_mode(sm0),
    .a(a0), .b(b0), .busy(busy0), .done(done0),
    .equalto(eq0), .greaterthan(gt0), .lessthan(lt0)
  );

  mag_compare_seq #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .signed_mode(sm1),
    .a(a1), .b(b1), .busy(busy1), .done(done1),
    .equalto(eq1), .greaterthan(gt1), .lessthan(lt1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor for the 32-bit instance.
  always @(negedge clk) begin : mon0
    exp_t e;
    if (reset) begin
      bc0 = 0;
    end else begin
      if (busy0) begin
        bc0++;
        check("scan_flags0", {29'd0, eq0, gt0, lt0}, 32'd0);
      end
      if (done0) begin
        if (q0.size() == 0) begin
          check("unexpected_done0", 32'd1, 32'd0);
        end else begin
          e = q0.pop_front();
          check("flags0", {29'd0, eq0, gt0, lt0}, {29'd0, e.eq, e.gt, e.lt});
          check("latency0", cyc - e.edge_cyc + 1, e.k);
          check("busy_cycles0", bc0, e.k - 1);
          check("busy_at_done0", {31'd0, busy0}, 32'd0);
        end
        bc0 = 0;
      end
    end
  end

  // Monitor for the 8-bit instance.
  always @(negedge clk) begin : mon1
    exp_t e;
    if (reset) begin
      bc1 = 0;
    end else begin
      if (busy1) begin
        bc1++;
        check("scan_flags1", {29'd0, eq1, gt1, lt1}, 32'd0);
      end
      if (done1) begin
        if (q1.size() == 0) begin
          check("unexpected_done1", 32'd1, 32'd0);
        end else begin
          e = q1.pop_front();
          check("flags1", {29'd0, eq1, gt1, lt1}, {29'd0, e.eq, e.gt, e.lt});
          check("latency1", cyc - e.edge_cyc + 1, e.k);
          check("busy_cycles1", bc1, e.k - 1);
        end
        bc1 = 0;
      end
    end
  end

  task automatic wait_idle0();
    for (int i = 0; i < 40 && q0.size() != 0; i++) @(negedge clk);
    if (q0.size() != 0) begin
      check("timeout0", 32'd1, 32'd0);
      q0.delete();
    end
  endtask

  task automatic wait_idle1();
    for (int i = 0; i < 40 && q1.size() != 0; i++) @(negedge clk);
    if (q1.size() != 0) begin
      check("timeout1", 32'd1, 32'd0);
      q1.delete();
    end
  endtask

  // Issue one compare on the 32-bit instance and wait for its result.
  task automatic run0(input logic [31:0] a, input logic [31:0] b, input logic sm,
                      input logic eq, input logic gt, input logic lt, input int k);
    exp_t e;
    @(negedge clk);
    a0 = a; b0 = b; sm0 = sm; start0 = 1'b1;
    e.eq = eq; e.gt = gt; e.lt = lt; e.edge_cyc = cyc + 1; e.k = k;
    q0.push_back(e);
    @(negedge clk);
    start0 = 1'b0;
    wait_idle0();
  endtask

  task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic sm,
                      input logic eq, input logic gt, input logic lt, input int k);
    exp_t e;
    @(negedge clk);
    a1 = a; b1 = b; sm1 = sm; start1 = 1'b1;
    e.eq = eq; e.gt = gt; e.lt = lt; e.edge_cyc = cyc + 1; e.k = k;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
    wait_idle1();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    exp_t e;
    reset = 1'b1;
    start0 = 1'b0; sm0 = 1'b0; a0 = '0; b0 = '0;
    start1 = 1'b0; sm1 = 1'b0; a1 = '0; b1 = '0;
    #1;
    check("reset_state0", {27'd0, busy0, done0, eq0, gt0, lt0}, 32'd0);
    check("reset_state1", {27'd0, busy1, done1, eq1, gt1, lt1}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Top-slice resolution, both modes.
    run0(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    run0(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b1, 2);
    run0(32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    run0(32'h0000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, 2);
    // Equality takes the full scan.
    run0(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, 9);
    // Difference in the bottom slice, signed.
    run0(32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 1'b1, 9);
    run0(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b1, 1'b0, 9);
    // Flags stay held while idle.
    repeat (4) @(negedge clk);
    check("held_flags0", {29'd0, eq0, gt0, lt0}, 32'b010);
    // Difference in slice 5: slices 7, 6, 5 examined.
    run0(32'h00F0_0000, 32'h00E0_0000, 1'b0, 1'b0, 1'b1, 1'b0, 4);

    // Second start mid-scan is ignored; operand changes are ignored.
    @(negedge clk);
    a0 = 32'hCAFE_BABE; b0 = 32'hCAFE_BABE; sm0 = 1'b0; start0 = 1'b1;
    e.eq = 1'b1; e.gt = 1'b0; e.lt = 1'b0; e.edge_cyc = cyc + 1; e.k = 9;
    q0.push_back(e);
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    start0 = 1'b1; a0 = 32'h0000_0000;
    @(negedge clk);
    start0 = 1'b0; a0 = 32'h0000_0001; sm0 = 1'b1;
    wait_idle0();
    repeat (12) @(negedge clk);

    // Asynchronous reset mid-scan abandons the compare.
    @(negedge clk);
    a0 = 32'h1234_5678; b0 = 32'h1234_5678; sm0 = 1'b0; start0 = 1'b1;
    e.eq = 1'b1; e.gt = 1'b0; e.lt = 1'b0; e.edge_cyc = cyc + 1; e.k = 9;
    q0.push_back(e);
    @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("busy_before_reset0", {31'd0, busy0}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_reset0", {27'd0, busy0, done0, eq0, gt0, lt0}, 32'd0);
    q0.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    run0(32'h0000_0010, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 1'b1, 8);

    // One-bit slices on the 8-bit instance.
    run1(8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0, 1'b0, 9);
    run1(8'h80, 8'h7F, 1'b1, 1'b0, 1'b0, 1'b1, 2);
    run1(8'h80, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    run1(8'h04, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 9);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mag_compare_seq.md
Name: mag_compare_seq

Overview:
- Parametrised sequential magnitude comparator; successor to the 4-bit combinational comparator.
- Compares two WIDTH-bit operands one DIGIT-bit slice per clock, MSB slice first, and stops as soon as a slice differs.
- Supports unsigned and two's-complement signed modes, with a start/busy/done handshake.
- Used wherever wide compares must not sit in one combinational path, e.g. ALU flag generation and timer match logic.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits compared per cycle; 1 <= DIGIT <= WIDTH.
- NDIG, WIDTH/DIGIT, derived local constant: number of slices.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a compare; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse when a result becomes valid.
- equalto  output  1  result: A == B.
- greaterthan  output  1  result: A > B.
- lessthan  output  1  result: A < B.

Behaviour:
- Reset (asynchronous, immediate, in any state): state = IDLE; busy, done, equalto, greaterthan, lessthan = 0; internal operand registers and index = 0. Any compare in progress is abandoned and produces no done pulse.
- States: IDLE, SCAN, DONE.
- IDLE:
  - start = 1 at an edge: latch a and b into ra and rb; XOR bit WIDTH-1 of each with signed_mode, which converts signed values to offset binary so the rest of the compare is purely unsigned.
  - Same edge: idx = NDIG-1, clear all three result flags, state = SCAN.
  - start = 0: no change.
- SCAN (busy = 1): each edge compares slice idx of ra against slice idx of rb, i.e. bits [idx*DIGIT+DIGIT-1 : idx*DIGIT].
  - Slice A > slice B: greaterthan = 1, state = DONE.
  - Slice A < slice B: lessthan = 1, state = DONE.
  - Slices equal, idx > 0: idx decrements, stay in SCAN.
  - Slices equal, idx = 0: equalto = 1, state = DONE.
- DONE: done = 1 for exactly this one cycle, busy = 0; next edge returns to IDLE unconditionally.
- start during SCAN or DONE is ignored; the requester must re-assert start in IDLE.
- Latency: done goes high k cycles after the start edge, where k = 1 + number of slices examined, so 2 <= k <= NDIG+1. Equality always takes the worst case, NDIG+1.
- Result flags:
  - Exactly one flag is high from the done cycle until the next accepted start.
  - All three flags are 0 after reset and during SCAN.
- Inputs a, b and signed_mode may change freely after the start edge; only the latched copies are used.
- DIGIT = WIDTH: one slice, so every result arrives with k = 2.
- Boundary operands:
  - Most-negative vs most-positive (0x80000000 vs 0x7FFFFFFF at WIDTH = 32) must resolve on the top slice in both modes.
  - All-zeros vs all-ones must resolve on the top slice.

Decomposition:
- Shared package mag_cmp_pkg:
  - State enum {IDLE, SCAN, DONE}.
  - Function ndig(width, digit) and a log2 helper sizing idx as $clog2(NDIG) bits, minimum 1.
- One natural sub-module, digit_compare: purely combinational, DIGIT-bit, outputs eq and gt; lt is derived as ~eq & ~gt.
- FSM, operand registers and result registers live in the top level.

Test Plan:
- WIDTH=32, DIGIT=4, unsigned, a=0x80000000, b=0x7FFFFFFF -> greaterthan=1, done 2 cycles after start; busy high for 1 cycle.
- Same operands, signed_mode=1 -> lessthan=1, done 2 cycles after start.
- a=b=0x12345678, unsigned -> equalto=1, done 9 cycles after start; gt and lt remain 0 throughout.
- a=0x00000001, b=0x00000002, signed -> lessthan=1, done 9 cycles after start. Then a=0xFFFFFFFF, b=0xFFFFFFFE signed -> greaterthan=1, done 9 cycles after start; flags stay held until the next start.
- Start a compare of equal operands, pulse start again in cycle 3, and change a mid-scan -> second start is ignored, result stays equalto=1, done exactly once at cycle 9.
- Assert reset asynchronously in cycle 4 of a scan -> all outputs are 0 immediately, no done pulse follows; a new start then completes normally. Repeat the equal-operand case with DIGIT=1, WIDTH=8 -> done 9 cycles after start.
